// File: rtl/apb_rr_arbiter_if.sv
// Bundles both requester command ports and the shared APB master bus of apb_rr_arbiter.
// Signals are combinational wires; all timing is owned by the arbiter that drives the master modport.
interface apb_rr_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              req0_valid;
   logic              req0_write;
   logic [ADDR_W-1:0] req0_addr;
   logic [DATA_W-1:0] req0_wdata;
   logic              req0_ready;
   logic              req0_done;
   logic              req0_err;
   logic [DATA_W-1:0] req0_rdata;

   logic              req1_valid;
   logic              req1_write;
   logic [ADDR_W-1:0] req1_addr;
   logic [DATA_W-1:0] req1_wdata;
   logic              req1_ready;
   logic              req1_done;
   logic              req1_err;
   logic [DATA_W-1:0] req1_rdata;

   logic              PSEL;
   logic              PENABLE;
   logic              PWRITE;
   logic [ADDR_W-1:0] PADDR;
   logic [DATA_W-1:0] PWDATA;
   logic [DATA_W-1:0] PRDATA;
   logic              PREADY;

   modport master (
      input  req0_valid, req0_write, req0_addr, req0_wdata,
      output req0_ready, req0_done, req0_err, req0_rdata,
      input  req1_valid, req1_write, req1_addr, req1_wdata,
      output req1_ready, req1_done, req1_err, req1_rdata,
      output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
      input  PRDATA, PREADY
   );

   modport slave (
      output req0_valid, req0_write, req0_addr, req0_wdata,
      input  req0_ready, req0_done, req0_err, req0_rdata,
      output req1_valid, req1_write, req1_addr, req1_wdata,
      input  req1_ready, req1_done, req1_err, req1_rdata,
      input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
      output PRDATA, PREADY
   );
endinterface

// File: rtl/apb_rr_arbiter.sv
// Two-requester round-robin APB master: grant->SETUP->ACCESS, done 3 cycles after grant plus wait states.
// Backpressure: a requester holds valid until its ready pulse; the loser waits in IDLE until the bus frees.
module apb_rr_arbiter #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 16
) (
   input  logic              PCLK,
   input  logic              PRESET,
   apb_rr_arbiter_if.master  bus
);
   typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

   localparam int WD_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

   state_t            state_q, state_d;
   logic              owner_q, owner_d;
   logic              last_grant_q, last_grant_d;
   logic              pwrite_q, pwrite_d;
   logic [ADDR_W-1:0] paddr_q, paddr_d;
   logic [DATA_W-1:0] pwdata_q, pwdata_d;
   logic [WD_W-1:0]   wdog_q, wdog_d;
   logic              ready0_q, ready0_d, ready1_q, ready1_d;
   logic              done0_q, done0_d, done1_q, done1_d;
   logic              err0_q, err0_d, err1_q, err1_d;
   logic [DATA_W-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
   logic              grant;

   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      last_grant_d = last_grant_q;
      pwrite_d     = pwrite_q;
      paddr_d      = paddr_q;
      pwdata_d     = pwdata_q;
      wdog_d       = wdog_q;
      rdata0_d     = rdata0_q;
      rdata1_d     = rdata1_q;
      ready0_d     = 1'b0;
      ready1_d     = 1'b0;
      done0_d      = 1'b0;
      done1_d      = 1'b0;
      err0_d       = 1'b0;
      err1_d       = 1'b0;
      // On a tie the requester that was not served last wins.
      grant = bus.req1_valid & (~bus.req0_valid | ~last_grant_q);

      case (state_q)
         IDLE: begin
            if (bus.req0_valid | bus.req1_valid) begin
               owner_d  = grant;
               pwrite_d = grant ? bus.req1_write : bus.req0_write;
               paddr_d  = grant ? bus.req1_addr  : bus.req0_addr;
               pwdata_d = grant ? bus.req1_wdata : bus.req0_wdata;
               ready0_d = ~grant;
               ready1_d = grant;
               wdog_d   = '0;
               state_d  = SETUP;
            end
         end
         SETUP: state_d = ACCESS;
         ACCESS: begin
            if (bus.PREADY) begin
               if (!pwrite_q) begin
                  if (owner_q) rdata1_d = bus.PRDATA;
                  else         rdata0_d = bus.PRDATA;
               end
               done0_d      = ~owner_q;
               done1_d      = owner_q;
               last_grant_d = owner_q;
               state_d      = IDLE;
            end else if (wdog_q == WD_LAST) begin
               done0_d      = ~owner_q;
               done1_d      = owner_q;
               err0_d       = ~owner_q;
               err1_d       = owner_q;
               last_grant_d = owner_q;
               state_d      = IDLE;
            end else begin
               wdog_d = wdog_q + WD_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
         state_q      <= IDLE;
         owner_q      <= 1'b0;
         last_grant_q <= 1'b1;
         pwrite_q     <= 1'b0;
         paddr_q      <= '0;
         pwdata_q     <= '0;
         wdog_q       <= '0;
         ready0_q     <= 1'b0;
         ready1_q     <= 1'b0;
         done0_q      <= 1'b0;
         done1_q      <= 1'b0;
         err0_q       <= 1'b0;
         err1_q       <= 1'b0;
         rdata0_q     <= '0;
         rdata1_q     <= '0;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         last_grant_q <= last_grant_d;
         pwrite_q     <= pwrite_d;
         paddr_q      <= paddr_d;
         pwdata_q     <= pwdata_d;
         wdog_q       <= wdog_d;
         ready0_q     <= ready0_d;
         ready1_q     <= ready1_d;
         done0_q      <= done0_d;
         done1_q      <= done1_d;
         err0_q       <= err0_d;
         err1_q       <= err1_d;
         rdata0_q     <= rdata0_d;
         rdata1_q     <= rdata1_d;
      end
   end

   // PSEL/PENABLE decode straight from state so reset drops them without waiting for a clock.
   assign bus.PSEL       = (state_q != IDLE);
   assign bus.PENABLE    = (state_q == ACCESS);
   assign bus.PWRITE     = pwrite_q;
   assign bus.PADDR      = paddr_q;
   assign bus.PWDATA     = pwdata_q;
   assign bus.req0_ready = ready0_q;
   assign bus.req1_ready = ready1_q;
   assign bus.req0_done  = done0_q;
   assign bus.req1_done  = done1_q;
   assign bus.req0_err   = err0_q;
   assign bus.req1_err   = err1_q;
   assign bus.req0_rdata = rdata0_q;
   assign bus.req1_rdata = rdata1_q;
endmodule

// File: tb/tb_apb_rr_arbiter.sv
// Directed bench for apb_rr_arbiter: per-cycle vector table plus hand-written timeout, back-to-back and reset sequences.
module tb_apb_rr_arbiter;
   logic pclk;
   logic preset;
   int   n_chk = 0;
   int   n_err = 0;
   int   cyc   = 0;

   apb_rr_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

   apb_rr_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(16)) dut (
      .PCLK   (pclk),
      .PRESET (preset),
      .bus    (bus)
   );

   initial pclk = 1'b0;
   always #5 pclk = ~pclk;

   // Column order: psel pen pwrite rdy0 rdy1 done0 done1 err0 err1
   logic [8:0] ctl_now;
   assign ctl_now = {bus.PSEL, bus.PENABLE, bus.PWRITE, bus.req0_ready, bus.req1_ready,
                     bus.req0_done, bus.req1_done, bus.req0_err, bus.req1_err};

   typedef struct {
      logic        rst;
      logic        v0, w0;
      logic [31:0] a0, d0;
      logic        v1, w1;
      logic [31:0] a1, d1;
      logic        prdy;
      logic [31:0] prd;
      logic [8:0]  ctl;
      logic [31:0] paddr, pwdata, rd0, rd1;
   } vec_t;

   vec_t tv[28];

   task automatic tick();
      @(posedge pclk);
      #1;
      cyc++;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   initial begin
      int prev_setup;
      logic [31:0] b2b_a[3];
      logic [31:0] b2b_d[3];

      //        rst v0 w0 a0     d0      v1 w1 a1     d1     prdy prd      ctl           paddr  pwdata rd0    rd1
      tv[0]  = '{1, 1, 1, 'h00,  'h05,   0, 0, 'h00,  'h00,  0, 'h000, 9'b000_00_00_00, 'h00,  'h00,  'h00,  'h00};
      tv[1]  = '{0, 1, 1, 'h00,  'h05,   0, 0, 'h00,  'h00,  0, 'h000, 9'b101_10_00_00, 'h00,  'h05,  'h00,  'h00};
      tv[2]  = '{0, 0, 0, 'h00,  'h00,   0, 0, 'h00,  'h00,  1, 'hBAD, 9'b111_00_00_00, 'h00,  'h05,  'h00,  'h00};
      tv[3]  = '{0, 0, 0, 'h00,  'h00,   0, 0, 'h00,  'h00,  0, 'h000, 9'b001_00_10_00, 'h00,  'h05,  'h00,  'h00};
      tv[4]  = '{1, 1, 1, 'h04,  'h07,   1, 1, 'h00,  'h03,  0, 'h000, 9'b000_00_00_00, 'h00,  'h00,  'h00,  'h00};
      tv[5]  = '{0, 1, 1, 'h04,  'h07,   1, 1, 'h00,  'h03,  0, 'h000, 9'b101_10_00_00, 'h04,  'h07,  'h00,  'h00};
      tv[6]  = '{0, 1, 1, 'h10,  'h11,   1, 1, 'h00,  'h03,  1, 'hBAD, 9'b111_00_00_00, 'h04,  'h07,  'h00,  'h00};
      tv[7]  = '{0, 1, 1, 'h10,  'h11,   1, 1, 'h00,  'h03,  0, 'h000, 9'b001_00_10_00, 'h04,  'h07,  'h00,  'h00};
      tv[8]  = '{0, 1, 1, 'h10,  'h11,   1, 1, 'h20,  'h21,  0, 'h000, 9'b101_01_00_00, 'h00,  'h03,  'h00,  'h00};
      tv[9]  = '{0, 1, 1, 'h10,  'h11,   1, 1, 'h20,  'h21,  1, 'hBAD, 9'b111_00_00_00, 'h00,  'h03,  'h00,  'h00};
      tv[10] = '{0, 1, 1, 'h10,  'h11,   1, 1, 'h20,  'h21,  0, 'h000, 9'b001_00_01_00, 'h00,  'h03,  'h00,  'h00};
      tv[11] = '{0, 1, 1, 'h30,  'h31,   1, 1, 'h20,  'h21,  0, 'h000, 9'b101_10_00_00, 'h10,  'h11,  'h00,  'h00};
      tv[12] = '{0, 1, 1, 'h30,  'h31,   1, 1, 'h20,  'h21,  1, 'hBAD, 9'b111_00_00_00, 'h10,  'h11,  'h00,  'h00};
      tv[13] = '{0, 1, 1, 'h30,  'h31,   1, 1, 'h20,  'h21,  0, 'h000, 9'b001_00_10_00, 'h10,  'h11,  'h00,  'h00};
      tv[14] = '{0, 1, 1, 'h30,  'h31,   1, 0, 'h08,  'h00,  0, 'h000, 9'b101_01_00_00, 'h20,  'h21,  'h00,  'h00};
      tv[15] = '{0, 1, 1, 'h30,  'h31,   1, 0, 'h08,  'h00,  1, 'hBAD, 9'b111_00_00_00, 'h20,  'h21,  'h00,  'h00};
      tv[16] = '{0, 1, 1, 'h30,  'h31,   1, 0, 'h08,  'h00,  0, 'h000, 9'b001_00_01_00, 'h20,  'h21,  'h00,  'h00};
      tv[17] = '{0, 0, 0, 'h00,  'h00,   1, 0, 'h08,  'h00,  0, 'h000, 9'b101_10_00_00, 'h30,  'h31,  'h00,  'h00};
      tv[18] = '{0, 0, 0, 'h00,  'h00,   1, 0, 'h08,  'h00,  1, 'hBAD, 9'b111_00_00_00, 'h30,  'h31,  'h00,  'h00};
      tv[19] = '{0, 0, 0, 'h00,  'h00,   1, 0, 'h08,  'h00,  0, 'h000, 9'b001_00_10_00, 'h30,  'h31,  'h00,  'h00};
      tv[20] = '{0, 0, 0, 'h00,  'h00,   1, 0, 'h08,  'h00,  0, 'h000, 9'b100_01_00_00, 'h08,  'h00,  'h00,  'h00};
      tv[21] = '{0, 0, 0, 'h00,  'h00,   0, 0, 'h00,  'h00,  0, 'h000, 9'b110_00_00_00, 'h08,  'h00,  'h00,  'h00};
      tv[22] = '{0, 0, 0, 'h00,  'h00,   0, 0, 'h00,  'h00,  0, 'h000, 9'b110_00_00_00, 'h08,  'h00,  'h00,  'h00};
      tv[23] = '{0, 0, 0, 'h00,  'h00,   0, 0, 'h00,  'h00,  1, 'h031, 9'b110_00_00_00, 'h08,  'h00,  'h00,  'h00};
      tv[24] = '{0, 1, 0, 'h0C,  'h00,   0, 0, 'h00,  'h00,  0, 'h000, 9'b000_00_01_00, 'h08,  'h00,  'h00,  'h31};
      tv[25] = '{0, 1, 0, 'h0C,  'h00,   0, 0, 'h00,  'h00,  0, 'h000, 9'b100_10_00_00, 'h0C,  'h00,  'h00,  'h31};
      tv[26] = '{0, 0, 0, 'h00,  'h00,   0, 0, 'h00,  'h00,  1, 'h055, 9'b110_00_00_00, 'h0C,  'h00,  'h00,  'h31};
      tv[27] = '{0, 0, 0, 'h00,  'h00,   0, 0, 'h00,  'h00,  0, 'h000, 9'b000_00_10_00, 'h0C,  'h00,  'h55,  'h31};

      preset = 1'b1;
      bus.req0_valid = 1'b0; bus.req0_write = 1'b0; bus.req0_addr = '0; bus.req0_wdata = '0;
      bus.req1_valid = 1'b0; bus.req1_write = 1'b0; bus.req1_addr = '0; bus.req1_wdata = '0;
      bus.PREADY = 1'b0; bus.PRDATA = '0;
      tick();

      // Each row is one clock cycle: outputs of that cycle, then inputs sampled at its closing edge.
      for (int i = 0; i < 28; i++) begin
         if (tv[i].rst) begin
            preset = 1'b1;
            #2;
            preset = 1'b0;
         end
         chk($sformatf("row%0d ctl", i),    {23'd0, ctl_now}, {23'd0, tv[i].ctl});
         chk($sformatf("row%0d paddr", i),  bus.PADDR,        tv[i].paddr);
         chk($sformatf("row%0d pwdata", i), bus.PWDATA,       tv[i].pwdata);
         chk($sformatf("row%0d rdata0", i), bus.req0_rdata,   tv[i].rd0);
         chk($sformatf("row%0d rdata1", i), bus.req1_rdata,   tv[i].rd1);
         bus.req0_valid = tv[i].v0; bus.req0_write = tv[i].w0;
         bus.req0_addr  = tv[i].a0; bus.req0_wdata = tv[i].d0;
         bus.req1_valid = tv[i].v1; bus.req1_write = tv[i].w1;
         bus.req1_addr  = tv[i].a1; bus.req1_wdata = tv[i].d1;
         bus.PREADY = tv[i].prdy;   bus.PRDATA = tv[i].prd;
         tick();
      end

      // Watchdog: req1 read against a slave that never answers.
      bus.req1_valid = 1'b1; bus.req1_write = 1'b0; bus.req1_addr = 'h14; bus.req1_wdata = '0;
      tick();
      chk("to setup ctl", {23'd0, ctl_now}, {23'd0, 9'b100_01_00_00});
      chk("to setup paddr", bus.PADDR, 'h14);
      bus.req1_valid = 1'b0;
      bus.PREADY = 1'b0;
      tick();
      for (int k = 1; k <= 16; k++) begin
         chk($sformatf("to access%0d ctl", k), {23'd0, ctl_now}, {23'd0, 9'b110_00_00_00});
         tick();
      end
      chk("to abort ctl", {23'd0, ctl_now}, {23'd0, 9'b000_00_01_01});
      chk("to abort rdata1", bus.req1_rdata, 'h31);
      tick();
      chk("to pulse end ctl", {23'd0, ctl_now}, {23'd0, 9'b000_00_00_00});

      // Read after the abort completes normally.
      bus.req1_valid = 1'b1; bus.req1_write = 1'b0; bus.req1_addr = 'h14;
      tick();
      chk("rd2 setup ctl", {23'd0, ctl_now}, {23'd0, 9'b100_01_00_00});
      bus.req1_valid = 1'b0;
      bus.PREADY = 1'b1; bus.PRDATA = 'h77;
      tick();
      chk("rd2 access ctl", {23'd0, ctl_now}, {23'd0, 9'b110_00_00_00});
      tick();
      chk("rd2 done ctl", {23'd0, ctl_now}, {23'd0, 9'b000_00_01_00});
      chk("rd2 rdata1", bus.req1_rdata, 'h77);
      chk("rd2 rdata0", bus.req0_rdata, 'h55);

      // Back-to-back: req0 swaps in its next command right after each ready.
      b2b_a[0] = 'h50; b2b_a[1] = 'h54; b2b_a[2] = 'h58;
      b2b_d[0] = 'h51; b2b_d[1] = 'h52; b2b_d[2] = 'h53;
      bus.req0_valid = 1'b1; bus.req0_write = 1'b1;
      bus.req0_addr = b2b_a[0]; bus.req0_wdata = b2b_d[0];
      prev_setup = 0;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk($sformatf("b2b%0d setup ctl", k), {23'd0, ctl_now}, {23'd0, 9'b101_10_00_00});
         chk($sformatf("b2b%0d paddr", k), bus.PADDR, b2b_a[k]);
         chk($sformatf("b2b%0d pwdata", k), bus.PWDATA, b2b_d[k]);
         if (k > 0) chk($sformatf("b2b%0d gap", k), cyc - prev_setup, 3);
         prev_setup = cyc;
         if (k < 2) begin
            bus.req0_addr = b2b_a[k+1]; bus.req0_wdata = b2b_d[k+1];
         end else begin
            bus.req0_valid = 1'b0;
         end
         tick();
         chk($sformatf("b2b%0d access ctl", k), {23'd0, ctl_now}, {23'd0, 9'b111_00_00_00});
         tick();
         chk($sformatf("b2b%0d done ctl", k), {23'd0, ctl_now}, {23'd0, 9'b001_00_10_00});
      end

      // Reset in the middle of ACCESS, then a tie that req0 must win.
      bus.req0_valid = 1'b1; bus.req0_write = 1'b1; bus.req0_addr = 'h40; bus.req0_wdata = 'h41;
      tick();
      bus.req0_valid = 1'b0;
      bus.PREADY = 1'b0;
      tick();
      chk("rst access ctl", {23'd0, ctl_now}, {23'd0, 9'b111_00_00_00});
      #2;
      preset = 1'b1;
      #1;
      chk("rst psel/penable", {30'd0, bus.PSEL, bus.PENABLE}, 0);
      bus.PREADY = 1'b1;
      tick();
      preset = 1'b0;
      chk("rst after ctl", {23'd0, ctl_now}, {23'd0, 9'b000_00_00_00});
      chk("rst after paddr", bus.PADDR, 0);
      tick();
      chk("rst no done ctl", {23'd0, ctl_now}, {23'd0, 9'b000_00_00_00});
      bus.req0_valid = 1'b1; bus.req0_write = 1'b1; bus.req0_addr = 'h60; bus.req0_wdata = 'h61;
      bus.req1_valid = 1'b1; bus.req1_write = 1'b1; bus.req1_addr = 'h64; bus.req1_wdata = 'h65;
      tick();
      chk("rst tie ctl", {23'd0, ctl_now}, {23'd0, 9'b101_10_00_00});
      chk("rst tie paddr", bus.PADDR, 'h60);
      bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
      tick();
      tick();
      chk("rst tie done ctl", {23'd0, ctl_now}, {23'd0, 9'b001_00_10_00});

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
